// File: rtl/ysyx_25020077_idu_pipe.sv
// Single-stage RV32I-subset decoder (addi/add/lui/jalr/ebreak) with a registered
// valid/ready output slot, a RUN/HALT state machine driven by ebreak, and an accept counter.
module ysyx_25020077_idu_pipe #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5,
   parameter int CNT_W     = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_in_valid,
   input  logic [31:0]          io_instruction,
   output logic                 io_in_ready,
   output logic                 io_out_valid,
   input  logic                 io_out_ready,
   output logic [2:0]           io_imm_type,
   output logic [RF_ADDR_W-1:0] io_rs1,
   output logic [RF_ADDR_W-1:0] io_rs2,
   output logic [RF_ADDR_W-1:0] io_rd,
   output logic [XLEN-1:0]      io_imm,
   output logic [2:0]           io_ALU_ctrl,
   output logic                 io_is_break,
   output logic                 io_illegal,
   input  logic                 io_resume,
   output logic                 io_halted,
   output logic [CNT_W-1:0]     io_dec_count
);

   // Handshake: a beat moves on a rising edge where valid & ready are both high;
   // a producer never waits for ready before raising valid, and a held beat stays stable.
   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

   state_t state_q, state_d;
   logic   accept;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rs1_f, rs2_f, rd_f;

   assign opcode = io_instruction[6:0];
   assign rd_f   = io_instruction[11:7];
   assign funct3 = io_instruction[14:12];
   assign rs1_f  = io_instruction[19:15];
   assign rs2_f  = io_instruction[24:20];
   assign funct7 = io_instruction[31:25];

   logic                 use_rs1, use_rs2, use_rd, known, reg_oob, dec_illegal, dec_break;
   logic [2:0]           dec_imm_type, dec_alu;
   logic [XLEN-1:0]      dec_imm, imm_i, imm_u;
   logic [RF_ADDR_W-1:0] dec_rs1, dec_rs2, dec_rd;

   assign imm_i = {{(XLEN-12){io_instruction[31]}}, io_instruction[31:20]};
   assign imm_u = XLEN'({io_instruction[31:12], 12'h000});

   // A register field is only representable if it fits the configured index width.
   function automatic logic field_oob(input logic [4:0] f);
      return 32'(f) >= (32'd1 << RF_ADDR_W);
   endfunction

   always_comb begin
      known        = 1'b0;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
      use_rd       = 1'b0;
      dec_break    = 1'b0;
      dec_imm_type = 3'd0;
      dec_alu      = 3'd0;
      dec_imm      = '0;
      if (io_instruction == EBREAK_WORD) begin
         known     = 1'b1;
         dec_break = 1'b1;
      end else begin
         case (opcode)
            7'b0010011: if (funct3 == 3'b000) begin
               known = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
               dec_imm_type = 3'd1; dec_imm = imm_i;
            end
            7'b0110011: if (funct3 == 3'b000 && funct7 == 7'b0) begin
               known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            7'b0110111: begin
               known = 1'b1; use_rd = 1'b1;
               dec_imm_type = 3'd2; dec_alu = 3'd1; dec_imm = imm_u;
            end
            7'b1100111: if (funct3 == 3'b000) begin
               known = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1;
               dec_imm_type = 3'd1; dec_alu = 3'd3; dec_imm = imm_i;
            end
            default: ;
         endcase
      end
      reg_oob     = (use_rs1 && field_oob(rs1_f)) || (use_rs2 && field_oob(rs2_f)) ||
                    (use_rd && field_oob(rd_f));
      dec_illegal = !known || reg_oob;
      dec_rs1     = (use_rs1 && !dec_illegal) ? rs1_f[RF_ADDR_W-1:0] : '0;
      dec_rs2     = (use_rs2 && !dec_illegal) ? rs2_f[RF_ADDR_W-1:0] : '0;
      dec_rd      = (use_rd  && !dec_illegal) ? rd_f[RF_ADDR_W-1:0]  : '0;
      if (dec_illegal) begin
         dec_imm_type = 3'd0;
         dec_alu      = 3'd7;
         dec_imm      = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // A resume arriving in the ebreak accept cycle is ignored: the machine is still in RUN then.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (accept && dec_break) state_d = ST_HALT;
         ST_HALT: if (io_resume)           state_d = ST_RUN;
      endcase
   end

   always_comb begin
      io_halted   = (state_q == ST_HALT);
      io_in_ready = (state_q == ST_RUN) && (!io_out_valid || io_out_ready);
   end

   assign accept = io_in_valid && io_in_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_out_valid <= 1'b0;
         io_imm_type  <= 3'd0;
         io_rs1       <= '0;
         io_rs2       <= '0;
         io_rd        <= '0;
         io_imm       <= '0;
         io_ALU_ctrl  <= 3'd0;
         io_is_break  <= 1'b0;
         io_illegal   <= 1'b0;
         io_dec_count <= '0;
      end else begin
         if (accept) begin
            io_out_valid <= 1'b1;
            io_imm_type  <= dec_imm_type;
            io_rs1       <= dec_rs1;
            io_rs2       <= dec_rs2;
            io_rd        <= dec_rd;
            io_imm       <= dec_imm;
            io_ALU_ctrl  <= dec_alu;
            io_is_break  <= dec_break;
            io_illegal   <= dec_illegal;
            io_dec_count <= io_dec_count + CNT_W'(1);
         end else if (io_out_ready) begin
            io_out_valid <= 1'b0;
         end
      end
   end

endmodule
